// File: rtl/clock_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_display_pkg
// Description : Shared constants and types for the six-digit clock display
//               scanner: active-high 7-segment patterns {g,f,e,d,c,b,a},
//               slot constants and the scan phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DP_SLOT_A  = 2;
    localparam int DP_SLOT_B  = 4;

    localparam logic [2:0] LAST_SLOT = 3'd5;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // PH_WAIT: out of reset, nothing shown yet; the first tick brings up slot 0
    // PH_DEAD: one-clock anti-ghost gap with all digit selects off
    // PH_LIT : digit select asserted until the next tick
    typedef enum logic [1:0] {
        PH_WAIT = 2'd0,
        PH_DEAD = 2'd1,
        PH_LIT  = 2'd2
    } phase_t;

    // Slot successor; the unreachable codes 6 and 7 recover to slot 0.
    function automatic logic [2:0] next_slot(input logic [2:0] s);
        return (s >= LAST_SLOT) ? 3'd0 : s + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_display_scan_bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD to active-high 7-segment decoder.
//               Codes 10..15 render as a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    // Digit lookup; anything outside 0..9 is shown as a dash
    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : clock_display_scan
// Description : Six-digit multiplexed 7-segment scanner for an HH:MM:SS BCD
//               counter. Snapshots the digits once per frame, decodes one
//               digit per slot, inserts a one-clock dead time on every slot
//               change and lights HH.MM.SS decimal points.
//               Optional macro CLOCK_DISPLAY_LZB_EN blanks a zero hours-tens
//               digit.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count5,
    input  logic [3:0] count4,
    input  logic [3:0] count3,
    input  logic [3:0] count2,
    input  logic [3:0] count1,
    input  logic [3:0] count0,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame_done
);

    localparam int             PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [6:0]     C_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic           C_DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [5:0]     C_DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_idx;
    phase_t           r_phase;
    logic [3:0]       r_sh [NUM_DIGITS];

    logic             w_tick;
    logic             w_snap;
    logic [2:0]       w_idx_new;
    logic [3:0]       w_count  [NUM_DIGITS];
    logic [3:0]       w_sh_new [NUM_DIGITS];
    logic [3:0]       w_bcd;
    logic [6:0]       w_pat;
    logic [6:0]       w_pat_shown;
    logic             w_blank;
    logic             w_dp_on;
    logic [5:0]       w_dig_on;

    assign w_count[0] = count0;
    assign w_count[1] = count1;
    assign w_count[2] = count2;
    assign w_count[3] = count3;
    assign w_count[4] = count4;
    assign w_count[5] = count5;

    assign w_tick = (r_pre == C_PRE_LAST);
    assign w_snap = w_tick && (r_idx == LAST_SLOT);

    // The first tick after reset brings up slot 0 rather than advancing past it.
    assign w_idx_new = (r_phase == PH_WAIT) ? 3'd0 : next_slot(r_idx);

    // Shadow values as they will be after this edge, so slot 0 shows a fresh
    // snapshot in the very cycle after the wrapping tick.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_sh_new[i] = w_snap ? w_count[i] : r_sh[i];
        end
    end

    // Select the digit for the slot being brought up
    always_comb begin
        w_bcd = 4'd0;
        case (w_idx_new)
            3'd0:    w_bcd = w_sh_new[0];
            3'd1:    w_bcd = w_sh_new[1];
            3'd2:    w_bcd = w_sh_new[2];
            3'd3:    w_bcd = w_sh_new[3];
            3'd4:    w_bcd = w_sh_new[4];
            3'd5:    w_bcd = w_sh_new[5];
            default: w_bcd = 4'd0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd     (w_bcd),
        .pattern (w_pat)
    );

`ifdef CLOCK_DISPLAY_LZB_EN
    assign w_blank = (w_idx_new == LAST_SLOT) && (w_sh_new[5] == 4'd0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_pat_shown = w_blank ? SEG_BLANK : w_pat;
    assign w_dp_on     = !w_blank && ((w_idx_new == 3'(DP_SLOT_A)) ||
                                      (w_idx_new == 3'(DP_SLOT_B)));
    assign w_dig_on    = 6'd1 << r_idx;

    // Slot-rate prescaler
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Slot index, scan phase and frame snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= 3'd0;
            r_phase <= PH_WAIT;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_sh[i] <= 4'd0;
            end
        end else if (w_tick) begin
            r_idx   <= w_idx_new;
            r_phase <= PH_DEAD;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_sh[i] <= w_sh_new[i];
            end
        end else if (r_phase == PH_DEAD) begin
            r_phase <= PH_LIT;
        end
    end

    // Registered, polarity-adjusted display drive and frame pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= C_SEG_OFF;
            dp         <= C_DP_OFF;
            dig_sel    <= C_DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_snap;
            if (w_tick) begin
                seg     <= (SEG_ACTIVE_LOW != 0) ? ~w_pat_shown : w_pat_shown;
                dp      <= (SEG_ACTIVE_LOW != 0) ? !w_dp_on : w_dp_on;
                dig_sel <= C_DIG_OFF;
            end else if (r_phase == PH_DEAD) begin
                dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~w_dig_on : w_dig_on;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_display_scan
// Description : Self-checking bench for clock_display_scan with SCAN_DIV = 4
//               and default (active-low) polarities.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_display_scan;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] count5, count4, count3, count2, count1, count0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_sel;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] cnt;
        int          slot;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vt [12];

    clock_display_scan #(
        .SCAN_DIV       (SD),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count5     (count5),
        .count4     (count4),
        .count3     (count3),
        .count2     (count2),
        .count1     (count1),
        .count0     (count0),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_counts(input logic [23:0] v);
        {count5, count4, count3, count2, count1, count0} = v;
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the cycle where frame_done is high,
    // i.e. slot 0 segments valid and digit selects in dead time.
    task automatic wait_frame();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        if (k == 100) begin
            total++;
            bad++;
            $display("FAIL frame_done timeout: got none want pulse within 100 clocks");
        end
    endtask

    // Starting at a frame_done cycle, checks dead cycle and first lit cycle of a slot.
    task automatic check_slot(input int slot, input logic [6:0] eseg, input logic edp, input string tag);
        logic [5:0] one;
        one = 6'd1 << slot;
        tick_n(SD * slot);
        chk($sformatf("%s slot%0d dead dig_sel", tag, slot), 32'(dig_sel), 32'h3F);
        chk($sformatf("%s slot%0d seg", tag, slot), 32'(seg), 32'(eseg));
        chk($sformatf("%s slot%0d dp", tag, slot), 32'(dp), 32'(edp));
        tick_n(1);
        chk($sformatf("%s slot%0d lit dig_sel", tag, slot), 32'(dig_sel), 32'(~one & 6'h3F));
        chk($sformatf("%s slot%0d lit seg", tag, slot), 32'(seg), 32'(eseg));
    endtask

    initial begin
        int last_fd;
        int deads;
        int frames;
        logic prev_dead;

        vt[0]  = '{24'h123456, 0, 7'h02, 1'b1};
        vt[1]  = '{24'h123456, 1, 7'h12, 1'b1};
        vt[2]  = '{24'h123456, 2, 7'h19, 1'b0};
        vt[3]  = '{24'h123456, 3, 7'h30, 1'b1};
        vt[4]  = '{24'h123456, 4, 7'h24, 1'b0};
        vt[5]  = '{24'h123456, 5, 7'h79, 1'b1};
        vt[6]  = '{24'h12345C, 0, 7'h3F, 1'b1};
        vt[7]  = '{24'h2359F8, 0, 7'h00, 1'b1};
        vt[8]  = '{24'h2359F8, 1, 7'h3F, 1'b1};
        vt[9]  = '{24'h2359F8, 2, 7'h10, 1'b0};
        vt[10] = '{24'hA00000, 5, 7'h3F, 1'b1};
        vt[11] = '{24'h070000, 4, 7'h78, 1'b0};

        // Reset state, then release and time the first slot
        set_counts(24'h123456);
        tick_n(3);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset dp", 32'(dp), 32'h1);
        chk("reset dig_sel", 32'(dig_sel), 32'h3F);
        chk("reset frame_done", 32'(frame_done), 32'h0);
        reset = 1'b1;
        tick_n(3);
        chk("pre-tick seg", 32'(seg), 32'h7F);
        tick_n(1);
        chk("first slot dead dig_sel", 32'(dig_sel), 32'h3F);
        chk("first slot zero shadow seg", 32'(seg), 32'h40);
        tick_n(1);
        chk("first slot dig_sel", 32'(dig_sel), 32'h3E);
        chk("first slot frame_done", 32'(frame_done), 32'h0);

        // Table-driven patterns
        for (int v = 0; v < 12; v++) begin
            set_counts(vt[v].cnt);
            wait_frame();
            check_slot(vt[v].slot, vt[v].seg, vt[v].dp, $sformatf("vec%0d", v));
        end

        // Mid-frame input change stays hidden until the next snapshot
        set_counts(24'h123453);
        wait_frame();
        wait_frame();
        chk("tear slot0 old", 32'(seg), 32'h30);
        tick_n(9);
        set_counts(24'h193457);
        tick_n(8);
        chk("tear slot4 old dig_sel", 32'(dig_sel), 32'h2F);
        chk("tear slot4 old seg", 32'(seg), 32'h24);
        wait_frame();
        chk("tear slot0 new", 32'(seg), 32'h78);
        tick_n(SD * 4);
        chk("tear slot4 new", 32'(seg), 32'h10);

        // Dead time is exactly one clock and frame period is 24 clocks
        wait_frame();
        last_fd   = 0;
        deads     = 0;
        frames    = 0;
        prev_dead = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (frame_done) begin
                frames++;
                chk($sformatf("frame period at %0d", c), 32'(c - last_fd), 32'd24);
                last_fd = c;
            end
            if (dig_sel == 6'h3F) begin
                deads++;
                if (prev_dead)
                    chk($sformatf("dead run length at %0d", c), 32'd2, 32'd1);
            end
            prev_dead = (dig_sel == 6'h3F);
        end
        chk("dead cycles in two frames", 32'(deads), 32'd12);
        chk("frames in 48 clocks", 32'(frames), 32'd2);

        // Asynchronous reset mid-slot 3
        set_counts(24'h012345);
        wait_frame();
        tick_n(SD * 3 + 2);
        chk("pre-reset slot3 dig_sel", 32'(dig_sel), 32'h37);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset seg", 32'(seg), 32'h7F);
        chk("async reset dp", 32'(dp), 32'h1);
        chk("async reset dig_sel", 32'(dig_sel), 32'h3F);
        chk("async reset frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick_n(SD + SD * 3);
        chk("post-reset slot3 dead", 32'(dig_sel), 32'h3F);
        chk("post-reset slot3 zero shadow", 32'(seg), 32'h40);

        // Hours-tens zero: blanked only with leading-zero blanking enabled
        wait_frame();
`ifdef CLOCK_DISPLAY_LZB_EN
        check_slot(5, 7'h7F, 1'b1, "lzb");
`else
        check_slot(5, 7'h40, 1'b1, "lzb");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
